mem_port_arbiter: RTL and testbench

Shares the single unified memory port between the instruction-fetch requester and the data load/store requester of the multicycle core. Replaces direct memory wiring so both paths use one memory macro. Handles one outstanding transaction at a time and sequences the fixed memory read latency, so the control unit's wait states line up with `i_rvalid`/`d_rvalid`. Arbitration is fixed-priority by default, with an optional fair (alternating) mode.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (I)
// and data load/store (D). One transaction in flight; reads are sequenced
// over the fixed memory latency RD_LAT (1..4). The FSM state is exported
// on dbg_state (0 = IDLE, 1 = RD_WAIT, 2 = RESP).
//
// Handshake: a requester raises req with stable addr/we/wdata/strb; gnt is
// a one-cycle pulse in the cycle the request drives the memory port. Req
// may drop before gnt (withdrawal). After gnt it drops the next cycle unless
// a new transaction is presented. A read returns with a one-cycle rvalid
// exactly RD_LAT cycles after gnt.
//
// Optional macro MEM_ARB_FAIR_EN: contested issues alternate between I and D.
// When it is undefined, D always beats I.
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_strb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_strb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       owner_d_q, owner_d_d;   // 1: read in flight belongs to D
  logic       pick_d;                 // D wins the current arbitration

`ifdef MEM_ARB_FAIR_EN
  logic last_d_q, last_d_d;           // D won the last contested issue

  // Contested issue goes to whoever did not win the previous contest
  always_comb begin
    pick_d   = d_req & (~i_req | ~last_d_q);
    last_d_d = last_d_q;
    if (!reset && state_q == IDLE && i_req && d_req) begin
      last_d_d = pick_d;
    end
  end

  // Fairness pointer register; starts as if I won last time
  always_ff @(posedge clk) begin
    if (reset) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  // Read data passes straight through from the memory macro
  assign rdata     = mem_rdata;
  assign dbg_state = state_q;

  // Next state, port mux and grant/response pulses
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d_d = owner_d_q;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_strb  = '0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            mem_en = 1'b1;
            if (pick_d) begin
              d_gnt    = 1'b1;
              mem_addr = d_addr;
              mem_we   = d_we;
              if (d_we) begin
                mem_wdata = d_wdata;
                mem_strb  = d_strb;
              end
            end else begin
              i_gnt    = 1'b1;
              mem_addr = i_addr;
            end
            // Stores complete at issue; reads wait out the latency
            if (!(pick_d && d_we)) begin
              cnt_d     = LAT_M1;
              owner_d_d = pick_d;
              state_d   = (RD_LAT == 1) ? RESP : RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) begin
            state_d = RESP;
          end
        end
        RESP: begin
          if (owner_d_q) begin
            d_rvalid = 1'b1;
          end else begin
            i_rvalid = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, latency counter and read owner registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      owner_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_d_q <= owner_d_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (RD_LAT = 1, 2, 3), each with
// a scripted opening followed by random requesters, a memory model and a
// transaction-level reference model compared every cycle.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam int NCYC = 2500;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
  } txn_t;

  task automatic chk(input string name, input int lat, input int cyc,
                     input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lat=%0d cyc=%0d got=%h want=%h", name, lat, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] rnd_addr();
    logic [3:0] idx;
    idx = 4'($urandom_range(0, 15));
    return {32'($urandom), 25'h0, idx, 3'b000};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lat_g
    localparam int L = g + 1;

    logic        reset, i_req, i_gnt, i_rvalid;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic        mem_en, mem_we;
    logic [63:0] i_addr, d_addr, d_wdata, rdata, mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  d_strb, mem_strb;
    logic [1:0]  dbg_state;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(L)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_strb(d_strb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_strb(mem_strb), .mem_rdata(mem_rdata),
      .dbg_state(dbg_state)
    );

    initial begin : run
      txn_t        i_q[$], d_q[$];
      txn_t        t;
      logic [63:0] env_mem[16];
      logic [63:0] mdl_mem[16];
      logic [64:0] ring[8];
      int          m_free, m_rv_at;
      logic        m_rv_d, m_last_d;
      logic [63:0] m_rv_data;
      int          eig[$], eir[$], edg[$], edr[$], ewe[$];
      int          x_ig[$], x_ir[$], x_dg[$], x_dr[$], x_we[$];
      logic        prev_ig, prev_dg, withdrew, issue, pick, rv;
      logic [63:0] e_addr;
      int          r, dir_end, dens;

      dir_end  = 4 * L + 15;
      m_free   = 0;
      m_rv_at  = -1;
      m_rv_d   = 1'b0;
      m_rv_data = '0;
      m_last_d = 1'b0;
      prev_ig  = 1'b0;
      prev_dg  = 1'b0;
      for (int i = 0; i < 16; i++) begin
        env_mem[i] = {$urandom, $urandom};
        mdl_mem[i] = env_mem[i];
      end
      env_mem[8] = 64'h13;
      mdl_mem[8] = 64'h13;
      for (int i = 0; i < 8; i++) ring[i] = '0;
      reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0; d_strb = '0; mem_rdata = '0;

      for (int c = 0; c < NCYC; c++) begin
        @(posedge clk); #1;
        if (prev_ig && i_q.size() > 0) i_q.delete(0);
        if (prev_dg && d_q.size() > 0) d_q.delete(0);
        r = c - 3;
        if (c < dir_end) begin
          reset = (c < 3) || (r == 3 * L + 7) || (r == 3 * L + 8);
          if (r == 0) i_q.push_back('{1'b0, 64'h40, 64'h0, 8'h0});
          if (r == L + 1) begin
            i_q.push_back('{1'b0, 64'h48, 64'h0, 8'h0});
            d_q.push_back('{1'b0, 64'h100, 64'h0, 8'h0});
          end
          if (r == 3 * L + 3) begin
            t = '{1'b1, 64'h200, 64'h0, 8'hFF}; t.wdata = {$urandom, $urandom};
            d_q.push_back(t);
            t = '{1'b1, 64'h208, 64'h0, 8'h0F}; t.wdata = {$urandom, $urandom};
            d_q.push_back(t);
          end
          if (r == 3 * L + 6) i_q.push_back('{1'b0, 64'h50, 64'h0, 8'h0});
          if (r == 3 * L + 9) i_q.push_back('{1'b0, 64'h58, 64'h0, 8'h0});
        end else begin
          reset = ($urandom_range(0, 99) == 0);
          dens  = ((c / 400) % 2 == 0) ? 85 : 35;
          withdrew = 1'b0;
          if (i_q.size() > 0 && $urandom_range(0, 15) == 0) begin
            i_q.delete(0); withdrew = 1'b1;
          end
          if (!withdrew && i_q.size() == 0 && $urandom_range(0, 99) < dens) begin
            t = '{1'b0, rnd_addr(), 64'h0, 8'h0};
            i_q.push_back(t);
          end
          withdrew = 1'b0;
          if (d_q.size() > 0 && $urandom_range(0, 15) == 0) begin
            d_q.delete(0); withdrew = 1'b1;
          end
          if (!withdrew && d_q.size() == 0 && $urandom_range(0, 99) < dens) begin
            t.we = 1'($urandom_range(0, 1));
            t.addr = rnd_addr();
            t.wdata = {$urandom, $urandom};
            t.strb = 8'($urandom);
            d_q.push_back(t);
          end
        end
        // Present queue heads; idle buses carry junk
        i_req  = (i_q.size() > 0);
        i_addr = i_req ? i_q[0].addr : {$urandom, $urandom};
        d_req  = (d_q.size() > 0);
        if (d_req) begin
          d_we = d_q[0].we; d_addr = d_q[0].addr;
          d_wdata = d_q[0].wdata; d_strb = d_q[0].strb;
        end else begin
          d_we = 1'($urandom); d_addr = {$urandom, $urandom};
          d_wdata = {$urandom, $urandom}; d_strb = 8'($urandom);
        end
        if (ring[c % 8][64]) begin
          mem_rdata = ring[c % 8][63:0];
          ring[c % 8] = '0;
        end else begin
          mem_rdata = {$urandom, $urandom};
        end

        @(negedge clk);
        // Reference model: the port is free from cycle m_free onward
        issue = !reset && (c >= m_free) && (i_req || d_req);
`ifdef MEM_ARB_FAIR_EN
        pick = d_req && (!i_req || !m_last_d);
`else
        pick = d_req;
`endif
        e_addr = issue ? (pick ? d_addr : i_addr) : 64'h0;
        rv = !reset && (c == m_rv_at);
        chk("idle", L, c, 64'(dbg_state == 2'd0), 64'(c >= m_free));
        chk("i_gnt", L, c, 64'(i_gnt), 64'(issue && !pick));
        chk("d_gnt", L, c, 64'(d_gnt), 64'(issue && pick));
        chk("mem_en", L, c, 64'(mem_en), 64'(issue));
        chk("mem_we", L, c, 64'(mem_we), 64'(issue && pick && d_we));
        chk("mem_addr", L, c, mem_addr, e_addr);
        chk("mem_strb", L, c, 64'(mem_strb), 64'((issue && pick && d_we) ? d_strb : 8'h0));
        if (!issue) chk("mem_wdata_idle", L, c, mem_wdata, 64'h0);
        if (issue && pick && d_we) chk("mem_wdata", L, c, mem_wdata, d_wdata);
        chk("i_rvalid", L, c, 64'(i_rvalid), 64'(rv && !m_rv_d));
        chk("d_rvalid", L, c, 64'(d_rvalid), 64'(rv && m_rv_d));
        chk("rdata_pass", L, c, rdata, mem_rdata);
        if (rv) chk("rdata", L, c, rdata, m_rv_data);

        // Advance the model
        if (reset) begin
          m_free = c + 1; m_rv_at = -1; m_last_d = 1'b0;
        end else if (issue) begin
          if (i_req && d_req) m_last_d = pick;
          if (pick && d_we) begin
            for (int b = 0; b < 8; b++)
              if (d_strb[b]) mdl_mem[d_addr[6:3]][b*8 +: 8] = d_wdata[b*8 +: 8];
            m_free = c + 1;
          end else begin
            m_rv_at = c + L; m_rv_d = pick;
            m_rv_data = mdl_mem[e_addr[6:3]];
            m_free = c + L + 1;
          end
        end

        // Memory macro behaviour, driven by what the DUT actually does
        if (mem_en && mem_we) begin
          for (int b = 0; b < 8; b++)
            if (mem_strb[b]) env_mem[mem_addr[6:3]][b*8 +: 8] = mem_wdata[b*8 +: 8];
        end else if (mem_en) begin
          ring[(c + L) % 8] = {1'b1, env_mem[mem_addr[6:3]]};
        end
        prev_ig = i_gnt;
        prev_dg = d_gnt;

        // Scripted opening: log events and pin them to hand-derived cycles
        if (c < dir_end) begin
          if (i_gnt) eig.push_back(r);
          if (i_rvalid) eir.push_back(r);
          if (d_gnt) edg.push_back(r);
          if (d_rvalid) edr.push_back(r);
          if (mem_we) ewe.push_back(r);
          if (i_rvalid && r == L) chk("fetch_word", L, c, rdata, 64'h13);
        end
        if (c == dir_end - 1) begin
          x_ig = '{0, 2 * L + 2, 3 * L + 6, 3 * L + 9};
          x_ir = '{L, 3 * L + 2, 4 * L + 9};
          x_dg = '{L + 1, 3 * L + 3, 3 * L + 4};
          x_dr = '{2 * L + 1};
          x_we = '{3 * L + 3, 3 * L + 4};
          chk("n_i_gnt", L, c, 64'(eig.size()), 64'(x_ig.size()));
          chk("n_i_rvalid", L, c, 64'(eir.size()), 64'(x_ir.size()));
          chk("n_d_gnt", L, c, 64'(edg.size()), 64'(x_dg.size()));
          chk("n_d_rvalid", L, c, 64'(edr.size()), 64'(x_dr.size()));
          chk("n_store", L, c, 64'(ewe.size()), 64'(x_we.size()));
          for (int k = 0; k < x_ig.size(); k++)
            chk("at_i_gnt", L, c, 64'((k < eig.size()) ? eig[k] : -1), 64'(x_ig[k]));
          for (int k = 0; k < x_ir.size(); k++)
            chk("at_i_rvalid", L, c, 64'((k < eir.size()) ? eir[k] : -1), 64'(x_ir[k]));
          for (int k = 0; k < x_dg.size(); k++)
            chk("at_d_gnt", L, c, 64'((k < edg.size()) ? edg[k] : -1), 64'(x_dg[k]));
          for (int k = 0; k < x_dr.size(); k++)
            chk("at_d_rvalid", L, c, 64'((k < edr.size()) ? edr[k] : -1), 64'(x_dr[k]));
          for (int k = 0; k < x_we.size(); k++)
            chk("at_store", L, c, 64'((k < ewe.size()) ? ewe[k] : -1), 64'(x_we[k]));
        end
      end
    end
  end

  initial begin
    repeat (NCYC + 3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
